// File: rtl/smi_master.sv
// MDIO/SMI clause-22 master: serialises one 64-bit management frame per
// accepted command on MDC/MDIO and returns read data plus a turnaround error.
module smi_master #(
   parameter int unsigned CLK_DIV = 10
) (
   input  logic        wb_clk_i,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        MDC,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   localparam int unsigned DIV_W = 8;
   localparam int unsigned BIT_W = 6;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // bit indices of frame landmarks
   localparam logic [BIT_W-1:0] BIT_HDR  = 6'd32;
   localparam logic [BIT_W-1:0] BIT_TA0  = 6'd46;
   localparam logic [BIT_W-1:0] BIT_TA1  = 6'd47;
   localparam logic [BIT_W-1:0] BIT_DATA = 6'd48;
   localparam logic [BIT_W-1:0] BIT_LAST = 6'd63;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d, bit_nx;
   logic             we_q, we_d;
   logic [31:0]      frame_q, frame_d;   // bits 32..63 of the frame, MSB first
   logic [15:0]      sh_q, sh_d;
   logic             err_q, err_d;
   logic             mdc_q, mdc_d;
   logic             mdio_o_q, mdio_o_d;
   logic             mdio_oe_q, mdio_oe_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [15:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             busy_q, busy_d;
   logic             cmd_ready_q, cmd_ready_d;

   assign bit_nx = bit_q + 6'd1;

   // drive value of frame bit k: preamble ones, then the latched header/data
   function automatic logic frame_bit(input logic [BIT_W-1:0] k, input logic [31:0] f);
      if (k < BIT_HDR) return 1'b1;
      return f[5'(BIT_LAST - k)];
   endfunction

   // next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      we_d        = we_q;
      frame_d     = frame_q;
      sh_d        = sh_q;
      err_d       = err_q;
      mdc_d       = mdc_q;
      mdio_o_d    = mdio_o_q;
      mdio_oe_d   = mdio_oe_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      busy_d      = busy_q;
      cmd_ready_d = cmd_ready_q;
      case (state_q)
         ST_IDLE: begin
            mdc_d       = 1'b0;
            mdio_o_d    = 1'b1;
            mdio_oe_d   = 1'b0;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
            if (cmd_valid && cmd_ready_q) begin
               state_d     = ST_SHIFT;
               div_d       = '0;
               bit_d       = '0;
               we_d        = cmd_we;
               frame_d     = {2'b01, cmd_we ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                              cmd_we ? 2'b10 : 2'b11, cmd_we ? cmd_wdata : 16'hFFFF};
               sh_d        = '0;
               err_d       = 1'b0;
               mdio_o_d    = 1'b1;
               mdio_oe_d   = 1'b1;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = '0;
               if (!mdc_q) begin
                  // end of low phase: raise MDC and sample the PHY on reads
                  mdc_d = 1'b1;
                  if (!we_q) begin
                     if (bit_q == BIT_TA1 && mdio_i) err_d = 1'b1;
                     if (bit_q >= BIT_DATA) sh_d = {sh_q[14:0], mdio_i};
                  end
               end else begin
                  mdc_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d     = ST_DONE;
                     mdio_o_d    = 1'b1;
                     mdio_oe_d   = 1'b0;
                     rsp_valid_d = 1'b1;
                     rsp_rdata_d = we_q ? 16'h0000 : sh_q;
                     rsp_err_d   = !we_q && err_q;
                  end else begin
                     bit_d     = bit_nx;
                     mdio_o_d  = frame_bit(bit_nx, frame_q);
                     mdio_oe_d = we_q || (bit_nx < BIT_TA0);
                  end
               end
            end
         end
         ST_DONE: begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         we_q        <= 1'b0;
         frame_q     <= '0;
         sh_q        <= '0;
         err_q       <= 1'b0;
         mdc_q       <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_oe_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         we_q        <= we_d;
         frame_q     <= frame_d;
         sh_q        <= sh_d;
         err_q       <= err_d;
         mdc_q       <= mdc_d;
         mdio_o_q    <= mdio_o_d;
         mdio_oe_q   <= mdio_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         busy_q      <= busy_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign MDC       = mdc_q;
   assign mdio_o    = mdio_o_q;
   assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_smi_master.sv
// Bench for smi_master: D=4 and D=2 instances, a monitor that captures the
// frame on MDC rising edges and plays a PHY, table vectors, hand sequences
// and random commands checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_smi_master;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        sel = 1'b0;          // 0 selects the D=4 instance, 1 the D=2 one
   logic        cmd_valid = 1'b0;
   logic        cmd_we = 1'b0;
   logic [4:0]  cmd_phy_addr = '0;
   logic [4:0]  cmd_reg_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        mdio_i = 1'b1;

   logic        valid_a, valid_b;
   logic        a_ready, a_rv, a_err, a_busy, a_mdc, a_o, a_oe;
   logic        b_ready, b_rv, b_err, b_busy, b_mdc, b_o, b_oe;
   logic [15:0] a_rd, b_rd;

   assign valid_a = cmd_valid & ~sel;
   assign valid_b = cmd_valid & sel;

   smi_master #(.CLK_DIV(4)) dut_d4 (
      .wb_clk_i(clk), .rst_n(rst_n), .cmd_valid(valid_a), .cmd_ready(a_ready),
      .cmd_we(cmd_we), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_err(a_err),
      .busy(a_busy), .MDC(a_mdc), .mdio_o(a_o), .mdio_oe(a_oe), .mdio_i(mdio_i));

   smi_master #(.CLK_DIV(2)) dut_d2 (
      .wb_clk_i(clk), .rst_n(rst_n), .cmd_valid(valid_b), .cmd_ready(b_ready),
      .cmd_we(cmd_we), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
      .cmd_wdata(cmd_wdata), .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_err(b_err),
      .busy(b_busy), .MDC(b_mdc), .mdio_o(b_o), .mdio_oe(b_oe), .mdio_i(mdio_i));

   logic        cur_ready, cur_rv, cur_err, cur_busy, cur_mdc, cur_o, cur_oe;
   logic [15:0] cur_rd;
   assign cur_ready = sel ? b_ready : a_ready;
   assign cur_rv    = sel ? b_rv    : a_rv;
   assign cur_err   = sel ? b_err   : a_err;
   assign cur_busy  = sel ? b_busy  : a_busy;
   assign cur_mdc   = sel ? b_mdc   : a_mdc;
   assign cur_o     = sel ? b_o     : a_o;
   assign cur_oe    = sel ? b_oe    : a_oe;
   assign cur_rd    = sel ? b_rd    : a_rd;

   int n_checks = 0;
   int n_fail   = 0;

   // monitor state
   logic [63:0] phy_bits = '1;       // value the PHY model puts on MDIO for bit k at [63-k]
   logic [63:0] cap_o = '0, cap_oe = '0;
   logic        mdc_prev = 1'b0;
   int          nedge = 0, ncyc = 0, hs_cyc = 0, hs_cnt = 0, rsp_cnt = 0;
   logic [63:0] r_o, r_oe;
   int          r_nedge, r_cyc;
   logic [15:0] r_data;
   logic        r_err, r_mdc, r_oel, r_busy;

   // frame capture on MDC rise, PHY model, handshake and response logging
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mdc_prev = 1'b0;
            nedge    = 0;
            mdio_i   = 1'b1;
         end else begin
            ncyc++;
            if (cmd_valid && cur_ready) begin
               hs_cyc = ncyc;
               cap_o  = '0;
               cap_oe = '0;
               nedge  = 0;
               mdio_i = phy_bits[63];
               hs_cnt++;
            end
            if (cur_mdc && !mdc_prev) begin
               cap_o  = {cap_o[62:0], cur_o};
               cap_oe = {cap_oe[62:0], cur_oe};
               nedge++;
               if (nedge < 64) mdio_i = phy_bits[63 - nedge];
            end
            mdc_prev = cur_mdc;
            if (cur_rv) begin
               r_o     = cap_o;
               r_oe    = cap_oe;
               r_nedge = nedge;
               r_cyc   = ncyc - hs_cyc;
               r_data  = cur_rd;
               r_err   = cur_err;
               r_mdc   = cur_mdc;
               r_oel   = cur_oe;
               r_busy  = cur_busy;
               rsp_cnt++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int got, input int need);
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got count %0d, required %0d", name, got, need);
   endtask

   task automatic wait_hs(input int target, input int budget, input string name);
      int n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (hs_cnt < target) timeout(name, hs_cnt, target);
   endtask

   task automatic wait_rsp(input int target, input int budget, input string name);
      int n = 0;
      while (rsp_cnt < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (rsp_cnt < target) timeout(name, rsp_cnt, target);
   endtask

   // reference: frame bit k sits at [63-k]
   function automatic logic [63:0] model_frame(input bit we, input logic [4:0] phy,
                                               input logic [4:0] regad, input logic [15:0] wdata);
      logic [63:0] f;
      f         = '1;
      f[31:30]  = 2'b01;
      f[29:28]  = we ? 2'b01 : 2'b10;
      f[27:23]  = phy;
      f[22:18]  = regad;
      f[17:16]  = 2'b10;
      f[15:0]   = wdata;
      return f;
   endfunction

   function automatic logic [63:0] model_oe(input bit we);
      logic [63:0] m;
      for (int k = 0; k < 64; k++) m[63-k] = we || (k < 46);
      return m;
   endfunction

   task automatic check_rsp(input string tag, input bit we, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [15:0] wdata,
                            input logic [15:0] exp_rd, input bit exp_err, input int exp_cyc);
      logic [63:0] ef, eo;
      ef = model_frame(we, phy, regad, wdata);
      eo = model_oe(we);
      check({tag, "/frame"}, r_o & eo, ef & eo);
      check({tag, "/oe"}, r_oe, eo);
      check({tag, "/edges"}, 64'(r_nedge), 64'd64);
      check({tag, "/cycle"}, 64'(r_cyc), 64'(exp_cyc));
      check({tag, "/rdata"}, 64'(r_data), 64'(exp_rd));
      check({tag, "/err"}, 64'(r_err), 64'(exp_err));
      check({tag, "/done_mdc_oe_busy"}, 64'({r_mdc, r_oel, r_busy}), 64'd1);
   endtask

   typedef struct {
      bit          sel;
      bit          we;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] wdata;
      bit          ta;
      logic [15:0] rd;
      logic [15:0] exp_rdata;
      bit          exp_err;
      int          exp_cyc;
      bit          chk_lo;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic run_txn(input string tag, input vec_t v);
      int h0, r0, dd;
      logic [63:0] eo, lo;
      dd       = v.sel ? 2 : 4;
      sel      = v.sel;
      phy_bits = {{47{1'b1}}, v.ta, v.rd};
      h0       = hs_cnt;
      r0       = rsp_cnt;
      @(posedge clk); #1;
      cmd_we       = v.we;
      cmd_phy_addr = v.phy;
      cmd_reg_addr = v.regad;
      cmd_wdata    = v.wdata;
      cmd_valid    = 1'b1;
      wait_hs(h0 + 1, 64, {tag, "/accept"});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_rsp(r0 + 1, 128 * dd + 40, {tag, "/rsp"});
      check_rsp(tag, v.we, v.phy, v.regad, v.we ? v.wdata : 16'hFFFF,
                v.exp_rdata, v.exp_err, v.exp_cyc);
      if (v.chk_lo) begin
         eo = model_oe(v.we);
         lo = r_o & eo;
         check({tag, "/frame_lo"}, 64'(lo[31:0]), 64'(v.exp_lo));
      end
      @(negedge clk);
      check({tag, "/idle_ready_busy_rv"}, 64'({cur_ready, cur_busy, cur_rv}), 64'd4);
      check({tag, "/held"}, 64'({cur_rd, cur_err}), 64'({v.exp_rdata, v.exp_err}));
   endtask

   localparam logic [22:0] RST_EXP = {7'b0010001, 16'h0000};

   vec_t tbl[4];

   initial begin
      int h0, r0, t1;
      vec_t v;

      tbl[0] = '{sel:1'b0, we:1'b1, phy:5'h01, regad:5'h00, wdata:16'h1140, ta:1'b0, rd:16'h0000,
                 exp_rdata:16'h0000, exp_err:1'b0, exp_cyc:513, chk_lo:1'b1, exp_lo:32'h5082_1140};
      tbl[1] = '{sel:1'b1, we:1'b1, phy:5'h00, regad:5'h00, wdata:16'hA5A5, ta:1'b0, rd:16'h0000,
                 exp_rdata:16'h0000, exp_err:1'b0, exp_cyc:257, chk_lo:1'b1, exp_lo:32'h5002_A5A5};
      tbl[2] = '{sel:1'b0, we:1'b0, phy:5'h1F, regad:5'h1F, wdata:16'h0000, ta:1'b1, rd:16'hFFFF,
                 exp_rdata:16'hFFFF, exp_err:1'b1, exp_cyc:513, chk_lo:1'b1, exp_lo:32'h6FFC_0000};
      tbl[3] = '{sel:1'b0, we:1'b0, phy:5'h03, regad:5'h02, wdata:16'h0000, ta:1'b0, rd:16'hBEEF,
                 exp_rdata:16'hBEEF, exp_err:1'b0, exp_cyc:513, chk_lo:1'b1, exp_lo:32'h6188_0000};

      // power-on reset
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", 64'({cur_mdc, cur_oe, cur_o, cur_rv, cur_err, cur_busy, cur_ready, cur_rd}),
            64'(RST_EXP));
      #2 rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

      // reset during bit 40 of a read: everything drops at once, no response
      sel      = 1'b0;
      phy_bits = {{47{1'b1}}, 1'b0, 16'h1234};
      h0 = hs_cnt;
      r0 = rsp_cnt;
      @(posedge clk); #1;
      cmd_we = 1'b0; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h01; cmd_valid = 1'b1;
      wait_hs(h0 + 1, 64, "midrst/accept");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int n = 0; n < 600 && nedge < 40; n++) begin
         @(negedge clk); #1;
      end
      if (nedge < 40) timeout("midrst/bit40", nedge, 40);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst/lines", 64'({cur_mdc, cur_oe, cur_o, cur_rv, cur_err, cur_busy, cur_ready, cur_rd}),
            64'(RST_EXP));
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst/no_rsp", 64'(rsp_cnt - r0), 64'd0);

      v = '{sel:1'b0, we:1'b0, phy:5'h03, regad:5'h02, wdata:16'h0000, ta:1'b0, rd:16'h1357,
            exp_rdata:16'h1357, exp_err:1'b0, exp_cyc:513, chk_lo:1'b0, exp_lo:32'h0};
      run_txn("after_rst", v);

      // cmd_valid held across two commands, fields changed mid-frame
      sel      = 1'b0;
      phy_bits = '1;
      h0 = hs_cnt;
      r0 = rsp_cnt;
      @(posedge clk); #1;
      cmd_we = 1'b1; cmd_phy_addr = 5'h0A; cmd_reg_addr = 5'h05; cmd_wdata = 16'h1234;
      cmd_valid = 1'b1;
      wait_hs(h0 + 1, 64, "b2b/accept1");
      repeat (100) @(negedge clk);
      #2;
      cmd_we = 1'b0; cmd_phy_addr = 5'h11; cmd_reg_addr = 5'h1E; cmd_wdata = 16'hFFFF;
      phy_bits = {{47{1'b1}}, 1'b0, 16'hC0DE};
      wait_rsp(r0 + 1, 600, "b2b/rsp1");
      check_rsp("b2b1", 1'b1, 5'h0A, 5'h05, 16'h1234, 16'h0000, 1'b0, 513);
      t1 = hs_cyc;
      wait_hs(h0 + 2, 20, "b2b/accept2");
      check("b2b/gap", 64'(hs_cyc - t1), 64'd514);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_rsp(r0 + 2, 600, "b2b/rsp2");
      check_rsp("b2b2", 1'b0, 5'h11, 5'h1E, 16'hFFFF, 16'hC0DE, 1'b0, 513);
      repeat (300) @(negedge clk);
      check("b2b/rsp_pulses", 64'(rsp_cnt - r0), 64'd2);
      check("b2b/accepts", 64'(hs_cnt - h0), 64'd2);

      // random commands against the reference model
      for (int i = 0; i < 8; i++) begin
         v.sel       = 1'($urandom_range(0, 1));
         v.we        = 1'($urandom_range(0, 1));
         v.phy       = 5'($urandom);
         v.regad     = 5'($urandom);
         v.wdata     = 16'($urandom);
         v.ta        = ($urandom_range(0, 3) == 0);
         v.rd        = 16'($urandom);
         v.exp_rdata = v.we ? 16'h0000 : v.rd;
         v.exp_err   = !v.we && v.ta;
         v.exp_cyc   = 128 * (v.sel ? 2 : 4) + 1;
         v.chk_lo    = 1'b0;
         v.exp_lo    = '0;
         run_txn($sformatf("rnd%0d", i), v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
